// File: rtl/ov5640_line_pkg.sv
// ----------------------------------------------------------------------------
// ov5640_line_pkg
// Shared definitions for the OV5640 line path (line collector and line
// serializer): default geometry, column index width, FSM state encoding and
// the border test used when emitting pixels.
// ----------------------------------------------------------------------------
package ov5640_line_pkg;

    localparam int LINE_W_DEFAULT = 320;
    localparam int BORDER_DEFAULT = 2;
    localparam int ROWS_DEFAULT   = 240;

    // Column index width; wide enough for the default 320-pixel line.
    localparam int COL_W = 9;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } line_state_e;

    // True when the column falls inside the forced-zero border at either edge.
    function automatic logic in_border(input logic [COL_W-1:0] col,
                                       input int line_w,
                                       input int border);
        return (int'(col) < border) || (int'(col) >= (line_w - border));
    endfunction

endpackage

// File: rtl/line_serializer.sv
// ----------------------------------------------------------------------------
// line_serializer
// Accepts a whole binary line (1 bit per pixel) and emits it one pixel per
// accepted cycle, with column/first/last/frame markers. The BORDER columns at
// each edge of the line are forced to 0. A new line can be accepted on the
// same edge as the last pixel of the current one, so lines stream gap-free.
//
// Ports:
//   clk         in   single clock, rising edge
//   rst         in   synchronous reset, active-high
//   line_in     in   [LINE_W] line to transmit, bit k = column k
//   line_valid  in   line_in is valid
//   line_ready  out  line_in is accepted this cycle
//   pix_data    out  current pixel
//   pix_valid   out  pixel outputs are valid
//   pix_ready   in   downstream accepts the pixel
//   pix_col     out  [9] column of the current pixel
//   pix_first   out  high with column 0
//   pix_last    out  high with column LINE_W-1
//   frame_last  out  high on every pixel of row ROWS-1
//   start       out  one-cycle pulse the cycle after a line is accepted
// ----------------------------------------------------------------------------
module line_serializer
    import ov5640_line_pkg::*;
#(
    parameter int LINE_W = LINE_W_DEFAULT,
    parameter int BORDER = BORDER_DEFAULT,
    parameter int ROWS   = ROWS_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [LINE_W-1:0] line_in,
    input  logic              line_valid,
    output logic              line_ready,
    output logic              pix_data,
    output logic              pix_valid,
    input  logic              pix_ready,
    output logic [COL_W-1:0]  pix_col,
    output logic              pix_first,
    output logic              pix_last,
    output logic              frame_last,
    output logic              start
);

    localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(LINE_W - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);

    line_state_e       state_q, state_d;
    logic [COL_W-1:0]  col_q, col_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic [LINE_W-1:0] buf_q, buf_d;
    logic              start_q, start_d;

    logic at_last;
    logic pix_fire;
    logic line_fire;

    assign at_last    = (col_q == COL_LAST);
    assign pix_valid  = (state_q == ST_SEND);
    assign pix_col    = col_q;
    assign pix_first  = pix_valid && (col_q == '0);
    assign pix_last   = pix_valid && at_last;
    assign frame_last = pix_valid && (row_q == ROW_LAST);
    assign start      = start_q;

    // A new line may be taken while idle, or on the edge that retires the
    // final pixel of the current line (gap-free back-to-back streaming).
    assign line_ready = (state_q == ST_IDLE) || (pix_valid && pix_ready && at_last);
    assign pix_fire   = pix_valid && pix_ready;
    assign line_fire  = line_valid && line_ready;

    // Pixel mux is the only combinational path from the line buffer.
    assign pix_data = pix_valid && !in_border(col_q, LINE_W, BORDER) && buf_q[col_q];

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        buf_d   = buf_q;
        start_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (line_fire) begin
                    state_d = ST_SEND;
                    col_d   = '0;
                    buf_d   = line_in;
                    start_d = 1'b1;
                end
            end
            ST_SEND: begin
                if (pix_fire) begin
                    if (at_last) begin
                        row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
                        col_d = '0;
                        if (line_fire) begin
                            buf_d   = line_in;
                            start_d = 1'b1;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            col_q   <= '0;
            row_q   <= '0;
            buf_q   <= '0;
            start_q <= 1'b0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            buf_q   <= buf_d;
            start_q <= start_d;
        end
    end

endmodule

// File: tb/tb_line_serializer.sv
// ----------------------------------------------------------------------------
// tb_line_serializer
// Directed bench for line_serializer (LINE_W=320, BORDER=2, ROWS=4).
// ----------------------------------------------------------------------------
module tb_line_serializer;

    localparam int LW = 320;

    logic          clk = 1'b0;
    logic          rst;
    logic [LW-1:0] line_in;
    logic          line_valid;
    logic          line_ready;
    logic          pix_data;
    logic          pix_valid;
    logic          pix_ready;
    logic [8:0]    pix_col;
    logic          pix_first;
    logic          pix_last;
    logic          frame_last;
    logic          start;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    line_serializer #(.LINE_W(LW), .BORDER(2), .ROWS(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .line_in    (line_in),
        .line_valid (line_valid),
        .line_ready (line_ready),
        .pix_data   (pix_data),
        .pix_valid  (pix_valid),
        .pix_ready  (pix_ready),
        .pix_col    (pix_col),
        .pix_first  (pix_first),
        .pix_last   (pix_last),
        .frame_last (frame_last),
        .start      (start)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Outputs expected while the block sits idle.
    task automatic chk_idle(input string tag);
        #1;
        chk({tag, "_valid"}, 32'(pix_valid), 0);
        chk({tag, "_lready"}, 32'(line_ready), 1);
        chk({tag, "_start"}, 32'(start), 0);
        chk({tag, "_first"}, 32'(pix_first), 0);
        chk({tag, "_last"}, 32'(pix_last), 0);
        chk({tag, "_flast"}, 32'(frame_last), 0);
        chk({tag, "_data"}, 32'(pix_data), 0);
    endtask

    // Offers a line and waits (bounded) for it to be taken.
    task automatic send_line(input logic [LW-1:0] pat);
        int n = 0;
        line_in    = pat;
        line_valid = 1'b1;
        pix_ready  = 1'b1;
        #1;
        while (!line_ready && n < 50) begin
            step();
            n++;
        end
        chk("send_lready", 32'(line_ready), 1);
        step();
        line_valid = 1'b0;
    endtask

    // Consumes ncols pixels of the current line, checking every cycle.
    // toggle: pix_ready alternates 1/0. pulse_col: column at which a stray
    // line_valid is raised for one cycle (-1 = none). b2b: offer next_in
    // throughout so it is taken on the last-pixel edge.
    task automatic stream(input logic [LW-1:0] pat, input bit toggle, input int row_exp,
                          input int ncols, input int pulse_col,
                          input bit b2b, input logic [LW-1:0] next_in);
        int  col = 0;
        int  cyc = 0;
        bit  pulsed = 0;
        bit  exp_d;
        if (b2b) begin
            line_in    = next_in;
            line_valid = 1'b1;
        end
        while (col < ncols && cyc < 2000) begin
            pix_ready = toggle ? ((cyc % 2) == 0) : 1'b1;
            if (pulse_col >= 0 && col == pulse_col && !pulsed) begin
                line_valid = 1'b1;
                line_in    = ~pat;
                pulsed     = 1;
            end else if (pulsed) begin
                line_valid = 1'b0;
                line_in    = pat;
            end
            #1;
            exp_d = (col >= 2 && col < 318) ? pat[col] : 1'b0;
            chk("px_valid", 32'(pix_valid), 1);
            chk("px_col", 32'(pix_col), 32'(col));
            chk("px_data", 32'(pix_data), 32'(exp_d));
            chk("px_first", 32'(pix_first), 32'(col == 0));
            chk("px_last", 32'(pix_last), 32'(col == 319));
            chk("px_flast", 32'(frame_last), 32'(row_exp == 3));
            chk("px_start", 32'(start), 32'(cyc == 0));
            chk("px_lready", 32'(line_ready), 32'(pix_ready && col == 319));
            if (pix_ready) col++;
            step();
            cyc++;
        end
        chk("xfer_count", 32'(col), 32'(ncols));
        if (col == 320) line_valid = 1'b0;
        pix_ready = 1'b1;
    endtask

    initial begin
        logic [LW-1:0] ones, alt, p1, p2;
        ones = '1;
        for (int k = 0; k < LW; k++) alt[k] = (k % 2 == 1);
        p1 = {10{32'hDEADBEEF}};
        p2 = {10{32'h0F1E2D3C}};

        // Reset
        rst = 1'b1; line_in = '0; line_valid = 1'b0; pix_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk_idle("reset");
        chk("reset_col", 32'(pix_col), 0);

        // All ones, pix_ready held high
        send_line(ones);
        stream(ones, 0, 0, 320, -1, 0, '0);
        chk_idle("ones_end");

        // Alternating pattern with stalls every other cycle
        send_line(alt);
        stream(alt, 1, 1, 320, -1, 0, '0);
        chk_idle("alt_end");

        // Back-to-back lines
        send_line(p1);
        stream(p1, 0, 2, 320, -1, 1, p2);
        stream(p2, 0, 3, 320, -1, 0, '0);
        chk_idle("b2b_end");

        // Fresh frame: five lines, row wraps after the fourth
        rst = 1'b1; step(); rst = 1'b0;
        chk_idle("rst2");
        for (int i = 0; i < 5; i++) begin
            send_line(i[0] ? p1 : p2);
            stream(i[0] ? p1 : p2, 0, i % 4, 320, -1, 0, '0);
        end
        send_line(p1); stream(p1, 0, 1, 320, -1, 0, '0);
        send_line(p2); stream(p2, 0, 2, 320, -1, 0, '0);

        // Abort mid-line on the last row of the frame
        send_line(ones);
        stream(ones, 0, 3, 100, -1, 0, '0);
        #1;
        chk("abort_col", 32'(pix_col), 100);
        chk("abort_flast", 32'(frame_last), 1);
        rst = 1'b1; step(); rst = 1'b0;
        chk_idle("abort");
        chk("abort_col0", 32'(pix_col), 0);

        // Restart at row 0 with a stray line_valid at column 50
        send_line(p1);
        stream(p1, 0, 0, 320, 50, 0, '0);
        chk_idle("pulse_end");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/line_serializer.md
LINE_SERIALIZER -- requirements
Module: line_serializer

Interface
REQ-001 Parameter LINE_W, default 320, pixels per line (binary, 1 bit per pixel).
REQ-002 Parameter BORDER, default 2, number of columns forced to 0 at each line edge.
REQ-003 Parameter ROWS, default 240, lines per frame.
REQ-004 The block SHALL have one clock and a synchronous, active-high reset, as listed in REQ-005 and REQ-006.
REQ-005 clk  in  1  single clock; all state changes on its rising edge.
REQ-006 rst  in  1  synchronous reset, active-high.
REQ-007 line_in  in  LINE_W  line to transmit; bit k is column k.
REQ-008 line_valid  in  1  line_in is valid.
REQ-009 line_ready  out  1  block accepts line_in this cycle.
REQ-010 pix_data  out  1  current pixel.
REQ-011 pix_valid  out  1  pix_data, pix_col, pix_first, pix_last and frame_last are valid.
REQ-012 pix_ready  in  1  downstream accepts the pixel.
REQ-013 pix_col  out  9  column index of the current pixel.
REQ-014 pix_first  out  1  high with column 0.
REQ-015 pix_last  out  1  high with column LINE_W-1.
REQ-016 frame_last  out  1  high on every pixel of row ROWS-1.
REQ-017 start  out  1  one-cycle pulse in the cycle after a line is accepted.

Function
REQ-018 Line handshake: a line transfers when line_valid and line_ready are both high on a clock edge; the block SHALL capture line_in into an internal LINE_W-bit buffer on that edge.
REQ-019 Pixel handshake: a pixel transfers when pix_valid and pix_ready are both high; pix_col SHALL then advance by 1.
REQ-020 FSM states: IDLE and SEND.
- IDLE -> SEND on line transfer.
- SEND -> IDLE on the pix_last transfer when no new line transfers on that edge.
- SEND -> SEND (pix_col reloaded to 0) when pix_last transfers and a new line transfers on the same edge.
REQ-021 line_ready SHALL be 1 in IDLE, and 1 in SEND only when pix_valid, pix_ready and pix_last are all high; 0 otherwise.
REQ-022 pix_valid SHALL equal 1 exactly when the state is SEND.
REQ-023 pix_data SHALL be 0 when pix_col < BORDER or pix_col >= LINE_W-BORDER; otherwise it SHALL be buffer bit [pix_col].
REQ-024 While pix_valid is high and pix_ready is low, all pixel outputs SHALL hold their values, with no loss or repetition.
REQ-025 Latency: the first pixel (pix_col=0, pix_first=1) SHALL be valid in the cycle after the line transfer; with pix_ready held high, a line occupies exactly LINE_W cycles.
REQ-026 Back-to-back lines with pix_ready held high SHALL stream with no gap cycle.
REQ-027 Row counter (0..ROWS-1): increments on each pix_last transfer and wraps from ROWS-1 to 0; frame_last = (row == ROWS-1) AND pix_valid.
REQ-028 start SHALL pulse for one cycle after every line transfer, including the back-to-back case.
REQ-029 A line_valid that arrives while line_ready is low SHALL be ignored (no capture); the upstream block holds line_in.

Reset
REQ-030 On rst high at a clock edge:
- state = IDLE, pix_col = 0, row = 0, buffer = 0.
- pix_valid = 0, pix_data = 0, pix_first = 0, pix_last = 0, frame_last = 0, start = 0.
- line_ready = 1 in the cycle following the edge.
REQ-031 Reset during SEND SHALL abort the line immediately; no further pixels of that line are emitted.

Structure
REQ-032 LINE_W, BORDER, ROWS defaults, the 9-bit column width and the FSM state encoding SHALL live in a shared package, ov5640_line_pkg, also used by the line collector.
REQ-033 Single module with no sub-modules; the pixel mux from buffer to pix_data is combinational, and everything else is registered.

Verification
REQ-034 Directed scenarios the bench SHALL cover:
- After reset, line_in = all ones, pix_ready = 1 -> 320 pixels, cols 0,1,318,319 = 0, all others 1, start pulse once, pix_first at col 0, pix_last at col 319.
- line_in = alternating 1010... (bit k = k odd), pix_ready toggling 1/0 every cycle -> 320 transfers, pix_data = (col odd) for cols 2..317, outputs stable while stalled.
- Two lines offered back-to-back, pix_ready = 1 -> 640 consecutive valid cycles, line_ready high only in the col-319 cycle, two start pulses.
- ROWS = 4, feed 5 lines -> frame_last high during line 4 only, row wraps to 0 for line 5.
- rst asserted at pix_col = 100 -> next cycle pix_valid = 0, line_ready = 1, next line restarts at col 0, row 0.
- line_valid pulsed mid-line (col 50) -> ignored, current line unchanged, line_ready stays 0.
